// File: rtl/system_test_pkg.sv
// Shared definitions for the system_test multicycle core: opcodes, ALU functions,
// FSM state codes and reset constants.
package system_test_pkg;

  localparam logic [3:0] OpAlu  = 4'h0;
  localparam logic [3:0] OpAddi = 4'h1;
  localparam logic [3:0] OpSw   = 4'h2;
  localparam logic [3:0] OpOri  = 4'h3;
  localparam logic [3:0] OpLw   = 4'h4;
  localparam logic [3:0] OpBeqz = 4'h5;
  localparam logic [3:0] OpJr   = 4'h6;
  localparam logic [3:0] OpLi   = 4'h7;

  localparam logic [3:0] AluAnd  = 4'h0;
  localparam logic [3:0] AluOr   = 4'h1;
  localparam logic [3:0] AluXor  = 4'h2;
  localparam logic [3:0] AluSub  = 4'h3;
  localparam logic [3:0] AluSll  = 4'h4;
  localparam logic [3:0] AluSrl  = 4'h5;
  localparam logic [3:0] AluSlt  = 4'h6;
  localparam logic [3:0] AluAdd  = 4'h7;
  localparam logic [3:0] AluPass = 4'h8;

  localparam logic [2:0] WbAlu = 3'd0;
  localparam logic [2:0] WbMem = 3'd1;
  localparam logic [2:0] WbImm = 3'd2;

  localparam logic [15:0] SpReset = 16'h03FF;

  typedef enum logic [8:0] {
    StFetch  = 9'd1,
    StDecode = 9'd2,
    StExec   = 9'd3,
    StRegWb  = 9'd4,
    StMemWr  = 9'd5,
    StMemRd  = 9'd6,
    StMemWb  = 9'd7
  } state_e;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/system_test_if.sv
// Debug/test access port plus observation signals of the system_test core.
interface system_test_if;

  logic        test;
  logic        memoryoperation;
  logic        registeroperation;
  logic        memorywrite;
  logic        registerwrite;
  logic [15:0] memwritedata;
  logic [15:0] memaddress;
  logic [15:0] resetpc;
  logic [15:0] regwritedata;
  logic [3:0]  registeraddress;

  logic [15:0] RD, MD, PC, SP;
  logic [9:1]  state;
  logic        FU, RW, PCW, SPW, MW, IW;
  logic [2:0]  ALUOp, RWSrc;
  logic        MSrc, LM, SrcB, Jump, SPIorD, IorD, Perform, LMC, z;
  logic [3:0]  Op;
  logic [15:0] x, display;
  logic [3:0]  y;

  modport master (
    output test, memoryoperation, registeroperation, memorywrite, registerwrite,
    output memwritedata, memaddress, resetpc, regwritedata, registeraddress,
    input  RD, MD, PC, SP, state, FU, RW, PCW, SPW, MW, IW, ALUOp, RWSrc,
    input  MSrc, LM, SrcB, Jump, SPIorD, IorD, Perform, LMC, z, Op, x, display, y
  );

  modport slave (
    input  test, memoryoperation, registeroperation, memorywrite, registerwrite,
    input  memwritedata, memaddress, resetpc, regwritedata, registeraddress,
    output RD, MD, PC, SP, state, FU, RW, PCW, SPW, MW, IW, ALUOp, RWSrc,
    output MSrc, LM, SrcB, Jump, SPIorD, IorD, Perform, LMC, z, Op, x, display, y
  );

endinterface

// File: rtl/system_test_alu16.sv
// Combinational 16-bit ALU with zero flag; function codes 8-F pass operand A.
module alu16
  import system_test_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [3:0]  fn_i,
  output logic [15:0] y_o,
  output logic        zero_o
);

  always_comb begin
    y_o = a_i;
    case (fn_i)
      AluAnd:  y_o = a_i & b_i;
      AluOr:   y_o = a_i | b_i;
      AluXor:  y_o = a_i ^ b_i;
      AluSub:  y_o = a_i - b_i;
      AluSll:  y_o = a_i << b_i[3:0];
      AluSrl:  y_o = a_i >> b_i[3:0];
      AluSlt:  y_o = {15'd0, ($signed(a_i) < $signed(b_i))};
      AluAdd:  y_o = a_i + b_i;
      default: y_o = a_i;
    endcase
  end

  assign zero_o = (y_o == 16'd0);

endmodule

// File: rtl/system_test.sv
// 16-bit multicycle core with 16x16 register file, 1K-word memory and a debug port
// that owns memory and registers while test=0.
module system_test
  import system_test_pkg::*;
(
  input logic         clk,
  input logic         reset,
  system_test_if.slave bus
);

  logic [15:0] regs [16];
  logic [15:0] mem  [1024];

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, sp_q, sp_d, ir_q, ir_d, md_q, md_d;
  logic [15:0] a_q, a_d, b_q, b_d, alu_q, alu_d;

  logic [3:0]  op, rd, rs, alu_fn;
  logic [15:0] imm, alu_b, alu_y, wb_data, mem_addr, mem_rdata;
  logic        alu_zero, srcb, msrc;
  logic        fu, rw, pcw, mw, iw, lm, lmc, jump, perform, iord;
  logic [2:0]  rw_src;

  assign op = ir_q[15:12];
  assign rd = ir_q[11:8];
  assign rs = ir_q[7:4];

  always_comb begin
    alu_fn = AluPass;
    case (op)
      OpAlu:   alu_fn = ir_q[3:0];
      OpAddi:  alu_fn = AluAdd;
      OpOri:   alu_fn = AluOr;
      default: alu_fn = AluPass;
    endcase
  end

  assign srcb  = (op == OpAddi) || (op == OpOri);
  assign imm   = (op == OpOri) ? {8'd0, ir_q[7:0]} : sext8(ir_q[7:0]);
  assign alu_b = srcb ? imm : b_q;

  alu16 u_alu (
    .a_i    (a_q),
    .b_i    (alu_b),
    .fn_i   (alu_fn),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  // The debug port takes the memory address whenever it is accessing memory.
  assign msrc      = !bus.test && bus.memoryoperation;
  assign mem_addr  = msrc ? bus.memaddress : (iord ? b_q : pc_q);
  assign mem_rdata = mem[mem_addr[9:0]];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    fu      = 1'b0;
    rw      = 1'b0;
    pcw     = 1'b0;
    mw      = 1'b0;
    iw      = 1'b0;
    lm      = 1'b0;
    lmc     = 1'b0;
    jump    = 1'b0;
    perform = 1'b0;
    iord    = 1'b0;
    rw_src  = WbAlu;
    if (bus.test) begin
      unique case (state_q)
        StFetch: begin
          iw      = 1'b1;
          pcw     = 1'b1;
          lm      = 1'b1;
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = StDecode;
        end
        StDecode: begin
          a_d = regs[rd];
          b_d = regs[rs];
          case (op)
            OpSw:    state_d = StMemWr;
            OpLw:    state_d = StMemRd;
            default: state_d = StExec;
          endcase
        end
        StExec: begin
          alu_d   = alu_y;
          state_d = StFetch;
          case (op)
            OpAlu, OpAddi, OpOri: begin
              fu      = 1'b1;
              state_d = StRegWb;
            end
            OpLi: state_d = StRegWb;
            OpBeqz: begin
              perform = alu_zero;
              pcw     = alu_zero;
              if (alu_zero) pc_d = pc_q + imm;
            end
            OpJr: begin
              jump = 1'b1;
              pcw  = 1'b1;
              pc_d = b_q;
            end
            default: ;
          endcase
        end
        StRegWb: begin
          rw      = 1'b1;
          rw_src  = (op == OpLi) ? WbImm : WbAlu;
          state_d = StFetch;
        end
        StMemWr: begin
          mw      = 1'b1;
          iord    = 1'b1;
          state_d = StFetch;
        end
        StMemRd: begin
          lm      = 1'b1;
          lmc     = 1'b1;
          iord    = 1'b1;
          state_d = StMemWb;
        end
        StMemWb: begin
          rw      = 1'b1;
          rw_src  = WbMem;
          state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    md_d = md_q;
    if (msrc || lm) md_d = mem_rdata;
  end

  always_comb begin
    case (rw_src)
      WbMem:   wb_data = md_q;
      WbImm:   wb_data = imm;
      default: wb_data = alu_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= bus.resetpc;
      sp_q    <= SpReset;
      ir_q    <= 16'd0;
      md_q    <= 16'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      alu_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ir_q    <= ir_d;
      md_q    <= md_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (msrc && bus.memorywrite) mem[bus.memaddress[9:0]] <= bus.memwritedata;
    else if (mw)                 mem[b_q[9:0]] <= a_q;
  end

  always_ff @(posedge clk) begin
    if (!bus.test && !bus.memoryoperation && bus.registeroperation && bus.registerwrite) begin
      regs[bus.registeraddress] <= bus.regwritedata;
    end else if (rw) begin
      regs[rd] <= wb_data;
    end
  end

  assign bus.RD      = bus.test ? regs[rs] : regs[bus.registeraddress];
  assign bus.MD      = md_q;
  assign bus.PC      = pc_q;
  assign bus.SP      = sp_q;
  assign bus.state   = state_q;
  assign bus.FU      = fu;
  assign bus.RW      = rw;
  assign bus.PCW     = pcw;
  assign bus.SPW     = 1'b0;
  assign bus.MW      = mw;
  assign bus.IW      = iw;
  assign bus.ALUOp   = alu_fn[2:0];
  assign bus.RWSrc   = rw_src;
  assign bus.MSrc    = msrc;
  assign bus.LM      = lm;
  assign bus.SrcB    = srcb;
  assign bus.Jump    = jump;
  assign bus.SPIorD  = 1'b0;
  assign bus.IorD    = iord;
  assign bus.Perform = perform;
  assign bus.LMC     = lmc;
  assign bus.z       = alu_zero;
  assign bus.Op      = op;
  assign bus.x       = alu_y;
  assign bus.display = wb_data;
  assign bus.y       = rd;

endmodule

// File: tb/tb_system_test.sv
// Directed bench for system_test: loads programs through the debug port, steps the core
// for fixed cycle counts and checks architectural state against hand-computed values.
module tb_system_test;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  system_test_if bus ();

  system_test dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic mem_wr(input logic [15:0] a, input logic [15:0] d);
    bus.memoryoperation = 1'b1;
    bus.memorywrite     = 1'b1;
    bus.memaddress      = a;
    bus.memwritedata    = d;
    @(posedge clk); #1;
    bus.memoryoperation = 1'b0;
    bus.memorywrite     = 1'b0;
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [15:0] d);
    bus.registeroperation = 1'b1;
    bus.registerwrite     = 1'b1;
    bus.registeraddress   = a;
    bus.regwritedata      = d;
    @(posedge clk); #1;
    bus.registeroperation = 1'b0;
    bus.registerwrite     = 1'b0;
  endtask

  task automatic mem_rd(input logic [15:0] a, output logic [15:0] d);
    bus.memoryoperation = 1'b1;
    bus.memorywrite     = 1'b0;
    bus.memaddress      = a;
    @(posedge clk); #1;
    d = bus.MD;
    bus.memoryoperation = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [15:0] d);
    bus.registeroperation = 1'b1;
    bus.registerwrite     = 1'b0;
    bus.registeraddress   = a;
    #1;
    d = bus.RD;
    bus.registeroperation = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] pc);
    bus.resetpc = pc;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    bus.test = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    bus.test = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (bus.state !== 9'd1) begin failures++; $display("FAIL rst_state got=%0d exp=1", bus.state); end
    checks++; if (bus.PC !== 16'h1234) begin failures++; $display("FAIL rst_pc got=%h exp=1234", bus.PC); end
    checks++; if (bus.SP !== 16'h03FF) begin failures++; $display("FAIL rst_sp got=%h exp=03ff", bus.SP); end
    checks++; if (bus.Op !== 4'h0) begin failures++; $display("FAIL rst_ir got=%h exp=0", bus.Op); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_li;
    logic [15:0] d;
    mem_wr(16'h0001, 16'h70FF);
    mem_wr(16'h0002, 16'h7105);
    do_reset(16'h0001);
    run(1);
    checks++; if (bus.state !== 9'd2) begin failures++; $display("FAIL fetch_state got=%0d exp=2", bus.state); end
    checks++; if (bus.MD !== 16'h70FF) begin failures++; $display("FAIL fetch_md got=%h exp=70ff", bus.MD); end
    checks++; if (bus.PC !== 16'h0002) begin failures++; $display("FAIL fetch_pc got=%h exp=0002", bus.PC); end
    run(3);
    checks++; if (bus.state !== 9'd1) begin failures++; $display("FAIL li_state got=%0d exp=1", bus.state); end
    run(4);
    reg_rd(4'd0, d);
    checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL li_r0 got=%h exp=ffff", d); end
    reg_rd(4'd1, d);
    checks++; if (d !== 16'h0005) begin failures++; $display("FAIL li_r1 got=%h exp=0005", d); end
  endtask

  task automatic test_alu_add;
    logic [15:0] d;
    reg_wr(4'd1, 16'd2);
    reg_wr(4'd3, 16'd10);
    mem_wr(16'h0010, 16'h0137);
    do_reset(16'h0010);
    run(4);
    reg_rd(4'd1, d);
    checks++; if (d !== 16'h000C) begin failures++; $display("FAIL add_r1 got=%h exp=000c", d); end
  endtask

  task automatic test_imm;
    logic [15:0] d;
    mem_wr(16'h0003, 16'h1005);
    mem_wr(16'h0004, 16'h1101);
    mem_wr(16'h0005, 16'h30EE);
    mem_wr(16'h0006, 16'h71FF);
    reg_wr(4'd0, 16'd11);
    reg_wr(4'd1, 16'h7FFF);
    do_reset(16'h0003);
    run(4);
    reg_rd(4'd0, d);
    checks++; if (d !== 16'h0010) begin failures++; $display("FAIL addi_r0 got=%h exp=0010", d); end
    run(4);
    reg_rd(4'd1, d);
    checks++; if (d !== 16'h8000) begin failures++; $display("FAIL addi_wrap got=%h exp=8000", d); end
    run(4);
    reg_rd(4'd0, d);
    checks++; if (d !== 16'h00FE) begin failures++; $display("FAIL ori_r0 got=%h exp=00fe", d); end
    run(4);
    reg_rd(4'd1, d);
    checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL li_neg got=%h exp=ffff", d); end
  endtask

  task automatic test_store;
    logic [15:0] d;
    mem_wr(16'h0007, 16'h2127);
    reg_wr(4'd2, 16'h0022);
    run(1);
    checks++; if (bus.state !== 9'd2) begin failures++; $display("FAIL sw_s2 got=%0d exp=2", bus.state); end
    run(1);
    checks++; if (bus.state !== 9'd5) begin failures++; $display("FAIL sw_s5 got=%0d exp=5", bus.state); end
    run(1);
    checks++; if (bus.state !== 9'd1) begin failures++; $display("FAIL sw_s1 got=%0d exp=1", bus.state); end
    mem_rd(16'h0022, d);
    checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL sw_mem got=%h exp=ffff", d); end
  endtask

  task automatic test_branch;
    logic [15:0] d;
    mem_wr(16'h0008, 16'h5005);
    mem_wr(16'h0009, 16'h7400);
    mem_wr(16'h000A, 16'h5403);
    mem_wr(16'h000E, 16'h6050);
    reg_wr(4'd5, 16'h0030);
    run(3);
    checks++; if (bus.PC !== 16'h0009) begin failures++; $display("FAIL beqz_nt got=%h exp=0009", bus.PC); end
    run(4);
    reg_rd(4'd4, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL li_zero got=%h exp=0000", d); end
    run(3);
    checks++; if (bus.PC !== 16'h000E) begin failures++; $display("FAIL beqz_t got=%h exp=000e", bus.PC); end
    run(3);
    checks++; if (bus.PC !== 16'h0030) begin failures++; $display("FAIL jr_pc got=%h exp=0030", bus.PC); end
  endtask

  task automatic test_load_alu;
    logic [15:0] d;
    mem_wr(16'h0030, 16'h4620);
    mem_wr(16'h0031, 16'h0123);
    mem_wr(16'h0032, 16'h0626);
    mem_wr(16'h0033, 16'h0724);
    reg_wr(4'd7, 16'h0003);
    run(2);
    checks++; if (bus.state !== 9'd6) begin failures++; $display("FAIL lw_s6 got=%0d exp=6", bus.state); end
    run(1);
    checks++; if (bus.state !== 9'd7) begin failures++; $display("FAIL lw_s7 got=%0d exp=7", bus.state); end
    run(1);
    reg_rd(4'd6, d);
    checks++; if (d !== 16'hFFFF) begin failures++; $display("FAIL lw_r6 got=%h exp=ffff", d); end
    run(4);
    reg_rd(4'd1, d);
    checks++; if (d !== 16'hFFDD) begin failures++; $display("FAIL sub_r1 got=%h exp=ffdd", d); end
    run(4);
    reg_rd(4'd6, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL slt_r6 got=%h exp=0001", d); end
    run(4);
    reg_rd(4'd7, d);
    checks++; if (d !== 16'h000C) begin failures++; $display("FAIL sll_r7 got=%h exp=000c", d); end
  endtask

  task automatic test_freeze_reset;
    logic [15:0] d;
    mem_wr(16'h0034, 16'h0127);
    run(2);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.state !== 9'd3) begin failures++; $display("FAIL frz_state got=%0d exp=3", bus.state); end
    checks++; if (bus.PC !== 16'h0035) begin failures++; $display("FAIL frz_pc got=%h exp=0035", bus.PC); end
    do_reset(16'h0040);
    checks++; if (bus.state !== 9'd1) begin failures++; $display("FAIL mid_state got=%0d exp=1", bus.state); end
    checks++; if (bus.PC !== 16'h0040) begin failures++; $display("FAIL mid_pc got=%h exp=0040", bus.PC); end
    reg_rd(4'd1, d);
    checks++; if (d !== 16'hFFDD) begin failures++; $display("FAIL mid_r1 got=%h exp=ffdd", d); end
  endtask

  task automatic test_debug_priority;
    logic [15:0] d;
    reg_wr(4'd9, 16'h1111);
    bus.memoryoperation   = 1'b1;
    bus.memorywrite       = 1'b1;
    bus.memaddress        = 16'h0050;
    bus.memwritedata      = 16'hA5A5;
    bus.registeroperation = 1'b1;
    bus.registerwrite     = 1'b1;
    bus.registeraddress   = 4'd9;
    bus.regwritedata      = 16'hBEEF;
    @(posedge clk); #1;
    bus.memoryoperation   = 1'b0;
    bus.memorywrite       = 1'b0;
    bus.registeroperation = 1'b0;
    bus.registerwrite     = 1'b0;
    reg_rd(4'd9, d);
    checks++; if (d !== 16'h1111) begin failures++; $display("FAIL prio_reg got=%h exp=1111", d); end
    mem_rd(16'h0050, d);
    checks++; if (d !== 16'hA5A5) begin failures++; $display("FAIL prio_mem got=%h exp=a5a5", d); end
  endtask

  initial begin
    bus.test              = 1'b0;
    bus.memoryoperation   = 1'b0;
    bus.registeroperation = 1'b0;
    bus.memorywrite       = 1'b0;
    bus.registerwrite     = 1'b0;
    bus.memwritedata      = 16'h0000;
    bus.memaddress        = 16'h0000;
    bus.resetpc           = 16'h1234;
    bus.regwritedata      = 16'h0000;
    bus.registeraddress   = 4'd0;
    #2;
    reset = 1'b0;
    test_reset();
    test_li();
    test_alu_add();
    test_imm();
    test_store();
    test_branch();
    test_load_alu();
    test_freeze_reset();
    test_debug_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
